fp_accum_seq: RTL and testbench

- Sequencing and accumulation stage placed directly upstream of the team's combinational FP32 add/sub unit. It also consumes that unit's result.
- Accepts a valid/ready stream of IEEE-754 single-precision elements, each tagged add or subtract.
- Each cycle it drives the running accumulator and the incoming element into the adder, then registers the adder result back into the accumulator.
- On packet end it presents the final sum, element count and sticky flags on a valid/ready output port.

---
 rtl/fp_accum_seq.sv | 84 ++++++++
 tb/tb_fp_accum_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fp_accum_seq.sv
// fp_accum_seq: packet accumulator that sequences FP32 beats through an external add/sub unit.
// Define FP_ACCUM_FLUSH_DENORM_EN to flush subnormal operands and results to signed zero.
module fp_accum_seq #(
  parameter int CNT_W   = 16,
  parameter int MAX_LEN = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [31:0]      adder_a,
  output logic [31:0]      adder_b,
  output logic             adder_sub,
  input  logic [31:0]      adder_result,
  input  logic             adder_exception,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_exception,
  output logic             out_truncated
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  logic [1:0]       state;
  logic [31:0]      acc;
  logic [CNT_W-1:0] count;
  logic             exc_sticky;
  logic [31:0]      res;
  logic [CNT_W:0]   count_nx;
  logic             closing;
`ifdef FP_ACCUM_FLUSH_DENORM_EN
  assign adder_b = (in_data[30:23] == 8'h0) ? {in_data[31], 31'h0} : in_data;
  assign res     = (adder_result[30:23] == 8'h0) ? {adder_result[31], 31'h0} : adder_result;
`else
  assign adder_b = in_data;
  assign res     = adder_result;
`endif
  assign adder_a   = acc;
  assign adder_sub = in_sub;
  assign in_ready  = state != HOLD;
  assign count_nx  = {1'b0, count} + (CNT_W+1)'(1);
  // MAX_LEN closure keeps the counter from ever wrapping
  assign closing   = in_last | (count_nx == (CNT_W+1)'(MAX_LEN));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      acc           <= 32'h0;
      count         <= '0;
      exc_sticky    <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= 32'h0;
      out_count     <= '0;
      out_exception <= 1'b0;
      out_truncated <= 1'b0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        out_valid  <= 1'b0;
        acc        <= 32'h0;
        count      <= '0;
        exc_sticky <= 1'b0;
        state      <= IDLE;
      end
    end else if (in_valid) begin
      acc        <= res;
      count      <= count_nx[CNT_W-1:0];
      exc_sticky <= exc_sticky | adder_exception;
      if (closing) begin
        out_data      <= res;
        out_count     <= count_nx[CNT_W-1:0];
        out_exception <= exc_sticky | adder_exception;
        out_truncated <= !in_last;
        out_valid     <= 1'b1;
        state         <= HOLD;
      end else begin
        state <= ACCUM;
      end
    end
  end
endmodule

// File: tb/tb_fp_accum_seq.sv
// tb_fp_accum_seq: directed and random checks of fp_accum_seq against a real-arithmetic packet model.
module tb_fp_accum_seq;
  localparam int CNT_W = 16;
  localparam int MAX_LEN = 4;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sub, in_last, adder_sub, adder_exception;
  logic out_valid, out_ready, out_exception, out_truncated;
  logic [31:0] in_data, adder_a, adder_b, adder_result, out_data;
  logic [CNT_W-1:0] out_count;
  int n_chk = 0, n_fail = 0;

  fp_accum_seq #(.CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sub(in_sub), .in_last(in_last), .adder_a(adder_a), .adder_b(adder_b),
    .adder_sub(adder_sub), .adder_result(adder_result), .adder_exception(adder_exception),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_exception(out_exception), .out_truncated(out_truncated)
  );

  always #5 clk = ~clk;

  function automatic real to_real(input logic [31:0] f);
    logic [10:0] e;
    e = {3'b000, f[30:23]} + 11'd896;
    return (f[30:23] == 8'h0) ? 0.0 : $bitstoreal({f[31], e, f[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] to_fp32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return (d[62:52] == 11'h0) ? {d[63], 31'h0} : {d[63], e[7:0], d[51:29]};
  endfunction

  // Environment stand-in for the combinational adder: inf/NaN operand raises exception and returns 0
  assign adder_exception = (adder_a[30:23] == 8'hFF) || (adder_b[30:23] == 8'hFF);
  assign adder_result = adder_exception ? 32'h0 :
    to_fp32(adder_sub ? to_real(adder_a) - to_real(adder_b) : to_real(adder_a) + to_real(adder_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: running real sum, beat count, sticky exception, presented result
  logic m_hold = 1'b0, m_exc = 1'b0, e_exc = 1'b0, e_trunc = 1'b0;
  real m_sum = 0.0, e_sum = 0.0;
  int m_cnt = 0, e_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold = 0; m_sum = 0.0; m_cnt = 0; m_exc = 0;
      e_sum = 0.0; e_cnt = 0; e_exc = 0; e_trunc = 0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0; m_sum = 0.0; m_cnt = 0; m_exc = 0;
      end
    end else if (in_valid) begin
      if (in_data[30:23] == 8'hFF) begin
        m_sum = 0.0;
        m_exc = 1;
      end else begin
        m_sum = in_sub ? m_sum - to_real(in_data) : m_sum + to_real(in_data);
      end
      m_cnt++;
      if (in_last || m_cnt == MAX_LEN) begin
        m_hold = 1; e_sum = m_sum; e_cnt = m_cnt; e_exc = m_exc; e_trunc = !in_last;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", {31'h0, in_ready}, {31'h0, !m_hold});
    chk("out_valid", {31'h0, out_valid}, {31'h0, m_hold});
    chk("adder_a", adder_a, to_fp32(m_sum));
    chk("adder_b", adder_b, in_data);
    chk("adder_sub", {31'h0, adder_sub}, {31'h0, in_sub});
    if (m_hold) begin
      chk("out_data", out_data, to_fp32(e_sum));
      chk("out_count", {16'h0, out_count}, e_cnt);
      chk("out_exception", {31'h0, out_exception}, {31'h0, e_exc});
      chk("out_truncated", {31'h0, out_truncated}, {31'h0, e_trunc});
    end
  end

  task automatic send(input logic [31:0] d, input logic s, input logic l);
    in_valid = 1; in_data = d; in_sub = s; in_last = l;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("idle_in_ready", {31'h0, in_ready}, 32'h1);
  endtask

  task automatic lit(input string name, input logic [31:0] d, input int c, input logic e, input logic t);
    chk({name, "_valid"}, {31'h0, out_valid}, 32'h1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_count"}, {16'h0, out_count}, c);
    chk({name, "_exc"}, {31'h0, out_exception}, {31'h0, e});
    chk({name, "_trunc"}, {31'h0, out_truncated}, {31'h0, t});
  endtask

  logic [31:0] held;
  initial begin
    in_valid = 0; in_data = 0; in_sub = 0; in_last = 0; out_ready = 0;
    rst = 0;
    #1 rst = 1;
    #10;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_count", {16'h0, out_count}, 32'h0);
    chk("rst_adder_a", adder_a, 32'h0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    send(32'h3F800000, 0, 0);
    send(32'h40000000, 0, 0);
    send(32'h3F000000, 1, 1);
    lit("p1", 32'h40200000, 3, 0, 0);
    drain();
    send(32'h40400000, 1, 1);
    lit("p2", 32'hC0400000, 1, 0, 0);
    drain();
    send(32'h7F800000, 0, 0);
    send(32'h3F800000, 0, 1);
    lit("p3", 32'h3F800000, 2, 1, 0);
    drain();
    repeat (4) send(32'h3F800000, 0, 0);
    lit("p4", 32'h40800000, 4, 0, 1);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_out_data", out_data, held);
    end
    drain();
    send(32'h3F800000, 0, 1);
    lit("p5", 32'h3F800000, 1, 0, 0);
    drain();
    send(32'h3F800000, 0, 0);
    send(32'h3F800000, 0, 0);
    #3 rst = 1;
    #1;
    chk("arst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_adder_a", adder_a, 32'h0);
    chk("arst_out_count", {16'h0, out_count}, 32'h0);
    @(posedge clk); #1 rst = 0;
    send(32'h3F800000, 0, 1);
    lit("p6", 32'h3F800000, 1, 0, 0);
    drain();
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom % 4) != 0;
      in_data = (($urandom % 16) == 0) ? 32'h7F800000 :
                to_fp32(0.25 * ($itor($urandom_range(0, 128)) - 64.0));
      in_sub = $urandom % 2;
      in_last = ($urandom % 4) == 0;
      out_ready = $urandom % 2;
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
